// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
//   Instruction-fetch stage sitting after the PC register (PCR). It runs one
//   outstanding request/acknowledge transaction to instruction memory,
//   buffers returned words with their PCs in a DEPTH-entry FIFO for decode,
//   and computes the next PC, which is fed back to PCR (PCR loads every
//   cycle, so pc_next equals pc_in whenever the PC does not advance).
//
// Parameters
//   RESET_PC    value driven on pc_next while reset is high
//   DEPTH       instruction FIFO entries (power of two, >= 2)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pc_in               current PC from PCR
//   pc_next             next PC to PCR (combinational)
//   redirect,
//   redirect_pc         taken branch/jump and its target
//   imem_req, imem_addr registered memory request and address
//   imem_ack,
//   imem_rdata          single-cycle acknowledge with instruction word
//   inst_valid,
//   inst_ready          FIFO head handshake towards decode
//   inst_out, inst_pc   head instruction and its PC
//   fetch_fault         sticky misaligned-PC flag
//
// Build option
//   IFU_ALIGN_CHECK_EN  when defined, a misaligned pc_in in IDLE blocks the
//                       request and sets fetch_fault until redirect/reset.
//                       When undefined, fetch_fault is 0 and the PC is
//                       force-aligned before it is used.
// ----------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        fifo_inst_q [DEPTH];
    logic [31:0]        fifo_pc_q   [DEPTH];

    logic               pop;
    logic               push;
    logic               space;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic [31:0]        pc_fetch;
    logic [31:0]        pc_inc;
    logic               misaligned;

`ifdef IFU_ALIGN_CHECK_EN
    logic               fault_q, fault_d;
    assign pc_fetch    = pc_in;
    assign misaligned  = (pc_in[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign pc_fetch    = {pc_in[31:2], 2'b00};
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign pc_inc        = pc_fetch + 32'd4;
    assign inst_valid    = (cnt_q != '0);
    assign pop           = inst_valid & inst_ready;
    assign cnt_after_pop = cnt_q - CNT_W'(pop);
    // Room for one more word once this cycle's pop has been taken.
    assign space         = (cnt_after_pop < CNT_W'(DEPTH));
    // A response is only kept when it arrives in WAIT without a redirect.
    assign push          = (state_q == S_WAIT) & imem_ack & ~redirect;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    // Storage is not reset, so the head is masked to 0 while empty.
    assign inst_out  = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
    assign inst_pc   = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;

    always_comb begin
        if (reset) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (push) begin
            pc_next = pc_inc;
        end else begin
            pc_next = pc_in;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
`ifdef IFU_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!redirect && space && !misaligned) begin
                    req_d   = 1'b1;
                    addr_d  = pc_fetch;
                    state_d = S_WAIT;
                end
`ifdef IFU_ALIGN_CHECK_EN
                if (!redirect && misaligned) begin
                    fault_d = 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if ((cnt_after_pop + CNT_W'(1)) < CNT_W'(DEPTH)) begin
                        // Back-to-back fetch keeps imem_req high.
                        addr_d  = pc_inc;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
`ifdef IFU_ALIGN_CHECK_EN
        if (redirect) begin
            fault_d = 1'b0;
        end
`endif
    end

    // A redirect flushes everything, including an entry popped this cycle.
    always_comb begin
        if (redirect) begin
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            cnt_d    = cnt_after_pop + CNT_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
`ifdef IFU_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
`ifdef IFU_ALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= addr_q;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] pc_next;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int mem_lat = 0;
    int wcnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] next_fill;
    logic        prev_ok = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    ifu_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // PC register upstream of the fetch stage.
    always @(posedge clk) pc_in <= pc_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [31:0] fetch_base(input logic [31:0] t);
`ifdef IFU_ALIGN_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference program order: sequential words from the last restart point.
    task automatic restart(input logic [31:0] base);
        exp_q.delete();
        next_fill = base;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(next_fill);
            next_fill = next_fill + 32'd4;
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_fill);
            next_fill = next_fill + 32'd4;
        end
    endtask

    // Instruction memory: acks mem_lat cycles after it first sees a request.
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (wcnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wcnt       = 0;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            restart(RST_PC);
            prev_ok = 1'b0;
        end else begin
            if (inst_valid && inst_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check32("sb_underflow", inst_pc, 32'hxxxx_xxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check32("sb_inst_pc", inst_pc, e);
                    check32("sb_inst_out", inst_out, mem_word(e));
                end
            end
            if (prev_ok && prev_req && !prev_ack && imem_req)
                check32("addr_stable", imem_addr, prev_addr);
`ifndef IFU_ALIGN_CHECK_EN
            check32("fault_tied", {31'h0, fetch_fault}, 32'h0);
`endif
            if (redirect) restart(fetch_base(redirect_pc));
            else topup();
            prev_ok = 1'b1;
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input logic level, input string name);
        int n;
        n = 0;
        while (imem_req !== level && n < 40) begin
            step();
            n++;
        end
        if (imem_req !== level) check32(name, {31'h0, imem_req}, {31'h0, level});
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        reset = 1'b1;
        redirect = 1'b0;
        mem_lat = lat;
        inst_ready = rdy;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect = 1'b1;
        redirect_pc = tgt;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        int n;
        // Reset values
        reset = 1'b1;
        step();
        step();
        #1;
        check32("rst_pc_next", pc_next, RST_PC);
        check32("rst_req", {31'h0, imem_req}, 32'h0);
        check32("rst_addr", imem_addr, 32'h0);
        check32("rst_valid", {31'h0, inst_valid}, 32'h0);
        check32("rst_inst_out", inst_out, 32'h0);
        check32("rst_inst_pc", inst_pc, 32'h0);
        check32("rst_fault", {31'h0, fetch_fault}, 32'h0);

        // Zero-wait memory, decode always ready: one word per cycle.
        do_reset(0, 1'b1);
        n = 0;
        while (!inst_valid && n < 20) begin step(); n++; end
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (inst_valid && inst_ready) n++;
            step();
        end
        check32("throughput", n, 16);

        // Backpressure fills exactly DEPTH entries.
        do_reset(0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        #1;
        check32("bp_valid", {31'h0, inst_valid}, 32'h1);
        check32("bp_req", {31'h0, imem_req}, 32'h0);
        check32("bp_pc_next", pc_next, 32'h8);
        check32("bp_head_pc", inst_pc, 32'h0);
        check32("bp_head_inst", inst_out, mem_word(32'h0));
        inst_ready = 1'b1;
        wait_req(1'b1, "bp_resume_timeout");
        check32("bp_resume_addr", imem_addr, 32'h8);
        for (int i = 0; i < 6; i++) step();

        // Redirect while waiting on a slow ack: response dropped.
        do_reset(3, 1'b1);
        wait_req(1'b1, "drop_req_timeout");
        do_redirect(32'h0000_0100);
        check32("drop_req_held", {31'h0, imem_req}, 32'h1);
        check32("drop_addr_held", imem_addr, 32'h0);
        wait_req(1'b0, "drop_drain_timeout");
        check32("drop_empty", {31'h0, inst_valid}, 32'h0);
        wait_req(1'b1, "drop_refetch_timeout");
        check32("drop_refetch_addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step();

        // Redirect in the same cycle as an ack.
        do_reset(2, 1'b1);
        n = 0;
        while (!imem_ack && n < 20) begin step(); n++; end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check32("rdack_pc_next", pc_next, 32'h0000_0200);
        step();
        redirect = 1'b0;
        check32("rdack_empty", {31'h0, inst_valid}, 32'h0);
        wait_req(1'b1, "rdack_refetch_timeout");
        check32("rdack_refetch_addr", imem_addr, 32'h0000_0200);
        for (int i = 0; i < 10; i++) step();

        // PC wraps past the top of the address space.
        mem_lat = 0;
        do_redirect(32'hFFFF_FFF8);
        n = 0;
        while (!(imem_ack && imem_addr == 32'hFFFF_FFFC) && n < 20) begin step(); n++; end
        #1;
        check32("wrap_pc_next", pc_next, 32'h0);
        for (int i = 0; i < 10; i++) step();

        // Misaligned redirect target.
`ifdef IFU_ALIGN_CHECK_EN
        do_redirect(32'h0000_0102);
        for (int i = 0; i < 6; i++) step();
        check32("mis_req", {31'h0, imem_req}, 32'h0);
        check32("mis_fault", {31'h0, fetch_fault}, 32'h1);
        check32("mis_empty", {31'h0, inst_valid}, 32'h0);
        do_redirect(32'h0000_0104);
        check32("mis_fault_clr", {31'h0, fetch_fault}, 32'h0);
        wait_req(1'b1, "mis_refetch_timeout");
        check32("mis_refetch_addr", imem_addr, 32'h0000_0104);
`else
        do_redirect(32'h0000_0102);
        wait_req(1'b1, "mis_refetch_timeout");
        check32("mis_aligned_addr", imem_addr, 32'h0000_0100);
`endif
        for (int i = 0; i < 10; i++) step();

        // Reset mid-transaction withdraws the request.
        do_reset(3, 1'b1);
        wait_req(1'b1, "rstmid_req_timeout");
        reset = 1'b1;
        step();
        check32("rstmid_req", {31'h0, imem_req}, 32'h0);
        check32("rstmid_valid", {31'h0, inst_valid}, 32'h0);
        reset = 1'b0;

        // Randomized traffic against the program-order scoreboard.
        for (int i = 0; i < 3000; i++) begin
            inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0) begin
                redirect = 1'b1;
                redirect_pc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 5) == 0) redirect_pc = 32'hFFFF_FFF0;
`ifndef IFU_ALIGN_CHECK_EN
                if ($urandom_range(0, 3) == 0) redirect_pc = $urandom;
`endif
            end else begin
                redirect = 1'b0;
            end
            step();
        end
        redirect = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (pops < 500) begin
            bad++;
            $display("FAIL progress: delivered %0d words, need at least 500", pops);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage directly downstream of the program counter register (PCR). It takes the current PC from PCR, runs a single-outstanding request/acknowledge transaction to instruction memory, and buffers returned instructions in a DEPTH-entry FIFO for decode. It also computes the next PC and feeds it back into PCR's `d_in`. Because PCR loads every cycle, `pc_next` must equal `pc_in` whenever the PC is not advancing.

## Interface
- `RESET_PC`, 32'h0000_0000, value driven on `pc_next` while `reset` is high
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pc_in`  in  32  current PC, driven by PCR `d_out`
- `pc_next`  out  32  next PC, drives PCR `d_in` (combinational)
- `redirect`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  32  redirect target
- `imem_req`  out  1  memory request (registered)
- `imem_addr`  out  32  request address (registered; stable while `imem_req`=1)
- `imem_ack`  in  1  single-cycle acknowledge; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `inst_valid`  out  1  FIFO non-empty
- `inst_ready`  in  1  decode accepts head entry
- `inst_out`  out  32  head instruction
- `inst_pc`  out  32  PC of head instruction
- `fetch_fault`  out  1  misaligned PC detected (only with the macro defined; otherwise tied to 0)

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding, response to be discarded.
- Space rule: `space` = (FIFO count after this cycle's pop) < DEPTH. Pop occurs when `inst_valid & inst_ready`.
- IDLE:
  - If `!redirect & space`: set `imem_req`<=1 and `imem_addr`<=`pc_in`, then go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, without `imem_ack`:
  - `redirect` → DROP.
  - Otherwise stay in WAIT.
- WAIT, with `imem_ack` and `!redirect`:
  - Push {`imem_addr`, `imem_rdata`} into the FIFO.
  - `pc_next`=`pc_in`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If space remains after the push, reissue immediately: `imem_addr`<=`pc_in`+4, `imem_req` stays 1, stay in WAIT.
  - Otherwise `imem_req`<=0 → IDLE.
- WAIT, with `imem_ack` and `redirect`: discard the data, `imem_req`<=0 → IDLE.
- DROP: `imem_req` and `imem_addr` stay held until `imem_ack`. On ack, discard the data, `imem_req`<=0 → IDLE.
- `redirect` in any state:
  - FIFO is flushed at the clock edge, including any entry popped that cycle.
  - `pc_next`=`redirect_pc`.
  - No request is issued that cycle.
- `pc_next` priority: `reset` → `RESET_PC`; else `redirect` → `redirect_pc`; else accepted ack in WAIT → `pc_in`+4; else `pc_in`.
- FIFO:
  - Simultaneous push and pop on a full FIFO is legal.
  - Overflow cannot occur, by the space rule.
  - Pop on empty is ignored.
- Memory protocol: at most one request outstanding. `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=0, `inst_valid`=0, `inst_out`=0, `inst_pc`=0, `fetch_fault`=0.
  - FSM=IDLE, FIFO empty.
  - `pc_next`=`RESET_PC` while `reset`=1.
- Reset mid-transaction aborts everything. Memory must tolerate request withdrawal on reset.
- Latency:
  - Request issues 1 cycle after entering IDLE with space.
  - Ack in cycle N makes `inst_valid` high in cycle N+1.
- Throughput with zero-wait ack (`imem_ack` high in the cycle after request) and `inst_ready`=1: 1 instruction/cycle after the first.
- Redirect to first request: the redirect cycle, then 1 cycle in IDLE, then the request with `imem_addr`=`redirect_pc`. If in DROP, the request follows the drained ack.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - In IDLE, if `pc_in[1:0]`≠0 and `!redirect`, no request is issued and `fetch_fault`<=1 (sticky).
  - `fetch_fault` clears on `redirect` or `reset`.
- `IFU_ALIGN_CHECK_EN` undefined:
  - `fetch_fault` is tied to 0.
  - `imem_addr` takes `{pc_in[31:2],2'b00}`.
  - `pc_next` increments from the aligned value.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory, `inst_ready`=1 → `pc_next`=0 during reset. Then fetches at 0, 4, 8, …, `inst_pc` sequential, 1 instruction/cycle after the first.
- `inst_ready`=0 with DEPTH=2 → exactly 2 entries (0, 4) buffered, `imem_req` low, `pc_next` holds 8. Raise `inst_ready` → fetch resumes at 8.
- `redirect` with `redirect_pc`=32'h0000_0100 while WAIT and ack delayed 3 cycles → DROP, stale word discarded, FIFO empty. Next request addresses 0x100.
- `redirect` in the same cycle as `imem_ack` → data not pushed, `pc_next`=`redirect_pc`, next fetch from the target.
- `pc_in`=32'hFFFF_FFFC, ack → `pc_next`=0 (wrap).
- With `IFU_ALIGN_CHECK_EN`, `redirect_pc`=32'h0000_0102 → no `imem_req`, `fetch_fault`=1 until the next redirect to 0x104, which clears it and fetches.
